// File: rtl/alu16.sv
// alu16: 16-bit registered ALU with one-cycle latency and a carry/borrow/error flag.
// Define ALU_MUL_EN to enable opcode 11 as an unsigned 16x16 multiply.
module alu16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [15:0] OP,
    output logic [16:0] result,
    output logic        error,
    output logic        out_valid
);

    logic [3:0]  w_sh;
    logic [16:0] w_sum;
    logic [16:0] w_diff;
    logic [16:0] w_inc;
    logic [16:0] w_dec;
    logic [15:0] w_shl;
    logic [15:0] w_shr;
    logic [15:0] w_sra;
    logic [15:0] w_rol;
    logic [15:0] w_ror;
    logic [4:0]  w_rsh;
    logic [16:0] w_res;
    logic        w_err;

    logic [16:0] r_result;
    logic        r_error;
    logic        r_valid;

    assign w_sh   = B[3:0];
    assign w_rsh  = 5'd16 - {1'b0, w_sh};
    assign w_sum  = {1'b0, A} + {1'b0, B};
    assign w_diff = {1'b0, A} - {1'b0, B};
    assign w_inc  = {1'b0, A} + 17'd1;
    assign w_dec  = {1'b0, A} - 17'd1;
    assign w_shl  = A << w_sh;
    assign w_shr  = A >> w_sh;
    assign w_sra  = $signed(A) >>> w_sh;
    // A shift of 16 yields zero, so the wrap-around term vanishes for a rotate by 0.
    assign w_rol  = (A << w_sh) | (A >> w_rsh);
    assign w_ror  = (A >> w_sh) | (A << w_rsh);

`ifdef ALU_MUL_EN
    logic [31:0] w_prod;
    logic        w_prod_ovf;
    assign w_prod     = A * B;
    assign w_prod_ovf = |w_prod[31:16];
`endif

    always_comb begin
        w_res = '0;
        w_err = 1'b0;
        if (OP[15:4] != 12'd0) begin
            w_err = 1'b1;
        end else begin
            case (OP[3:0])
                4'd0:  begin w_res = w_sum;  w_err = w_sum[16];  end
                4'd1:  begin w_res = w_diff; w_err = w_diff[16]; end
                4'd2:  w_res = {1'b0, A & B};
                4'd3:  w_res = {1'b0, A | B};
                4'd4:  w_res = {1'b0, A ^ B};
                4'd5:  w_res = {1'b0, ~A};
                4'd6:  w_res = {1'b0, w_shl};
                4'd7:  w_res = {1'b0, w_shr};
                4'd8:  w_res = {1'b0, w_sra};
                4'd9:  w_res = {1'b0, w_rol};
                4'd10: w_res = {1'b0, w_ror};
`ifdef ALU_MUL_EN
                4'd11: begin w_res = {w_prod_ovf, w_prod[15:0]}; w_err = w_prod_ovf; end
`else
                4'd11: w_err = 1'b1;
`endif
                4'd12: begin w_res = w_inc;  w_err = w_inc[16];  end
                4'd13: begin w_res = w_dec;  w_err = w_dec[16];  end
                4'd14: w_res = {1'b0, A};
                4'd15: w_res = {1'b0, B};
                default: w_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_error  <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_result <= w_res;
                r_error  <= w_err;
            end
        end
    end

    assign result    = r_result;
    assign error     = r_error;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_alu16.sv
// Self-checking bench for alu16: directed vector table, random stimulus against an
// arithmetic reference model, hold behaviour and asynchronous reset.
module tb_alu16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] A, B, OP;
    logic [16:0] result;
    logic        error;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    alu16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .OP        (OP),
        .result    (result),
        .error     (error),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] op;
        logic [16:0] r;
        logic        e;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the opcode definitions.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] op);
        longint ia, ib, s, t;
        logic [16:0] r;
        logic e;
        ia = a; ib = b; s = b % 16;
        r = '0; e = 1'b0; t = 0;
        if (op > 15) begin
            e = 1'b1;
        end else begin
            case (op)
                0:  begin t = ia + ib; r = t[16:0]; e = r[16]; end
                1:  begin t = ia - ib; r = t[16:0]; e = (ia < ib); end
                2:  r = {1'b0, a & b};
                3:  r = {1'b0, a | b};
                4:  r = {1'b0, a ^ b};
                5:  begin t = 65535 - ia; r = t[16:0]; end
                6:  begin t = (ia * (64'd1 << s)) % 65536; r = t[16:0]; end
                7:  begin t = ia / (64'd1 << s); r = t[16:0]; end
                8:  begin
                        t = (ia >= 32768) ? ia - 65536 : ia;
                        t = t >>> s;
                        t = (t < 0) ? t + 65536 : t;
                        r = t[16:0];
                    end
                9:  begin t = (ia * (64'd1 << s) + ia / (64'd1 << (16 - s))) % 65536;
                          r = t[16:0]; end
                10: begin t = (ia / (64'd1 << s) + ia * (64'd1 << (16 - s))) % 65536;
                          r = t[16:0]; end
                11: begin
`ifdef ALU_MUL_EN
                        t = ia * ib;
                        e = (t >= 65536);
                        r = {e, t[15:0]};
`else
                        e = 1'b1;
`endif
                    end
                12: begin t = ia + 1; r = t[16:0]; e = (t > 65535); end
                13: begin t = ia - 1; r = t[16:0]; e = (ia == 0); end
                14: r = {1'b0, a};
                default: r = {1'b0, b};
            endcase
        end
        return {e, r};
    endfunction

    task automatic run_vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] op, input logic [16:0] er, input logic ee);
        A = a; B = b; OP = op; in_valid = 1'b1;
        @(posedge clk); #1;
        check({tag, " result"}, 32'(result), 32'(er));
        check({tag, " error"}, 32'(error), 32'(ee));
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [17:0] m;
        logic [16:0] last_r;
        logic        last_e;

        tbl.push_back('{16'h0001, 16'h0001, 16'd0,  17'h00002, 1'b0});
        tbl.push_back('{16'hFFFF, 16'h0001, 16'd0,  17'h10000, 1'b1});
        tbl.push_back('{16'h0000, 16'h0001, 16'd1,  17'h1FFFF, 1'b1});
        tbl.push_back('{16'h8001, 16'h0004, 16'd8,  17'h0F800, 1'b0});
        tbl.push_back('{16'h8001, 16'h0004, 16'd9,  17'h00018, 1'b0});
        tbl.push_back('{16'h8001, 16'h0004, 16'd10, 17'h01800, 1'b0});
        tbl.push_back('{16'h8001, 16'h0004, 16'h0010, 17'h00000, 1'b1});
        tbl.push_back('{16'h1234, 16'h0000, 16'd6,  17'h01234, 1'b0});
        tbl.push_back('{16'h1234, 16'h0010, 16'd9,  17'h01234, 1'b0});
        tbl.push_back('{16'h8001, 16'h0000, 16'd8,  17'h08001, 1'b0});
        tbl.push_back('{16'hFFFF, 16'h0000, 16'd12, 17'h10000, 1'b1});
        tbl.push_back('{16'h0000, 16'h0000, 16'd13, 17'h1FFFF, 1'b1});
        tbl.push_back('{16'h00F0, 16'h0F0F, 16'd5,  17'h0FF0F, 1'b0});
`ifdef ALU_MUL_EN
        tbl.push_back('{16'h0100, 16'h0100, 16'd11, 17'h10000, 1'b1});
        tbl.push_back('{16'h0003, 16'h0005, 16'd11, 17'h0000F, 1'b0});
`else
        tbl.push_back('{16'h0003, 16'h0005, 16'd11, 17'h00000, 1'b1});
`endif

        rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; OP = '0;
        #1;
        check("reset result", 32'(result), 32'd0);
        check("reset error", 32'(error), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) run_vec($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].op,
                                 tbl[i].r, tbl[i].e);
        last_r = tbl[tbl.size()-1].r;
        last_e = tbl[tbl.size()-1].e;

        // Idle cycles hold the last result while out_valid drops.
        in_valid = 1'b0; A = 16'h5555; B = 16'h0001; OP = 16'd0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("hold result", 32'(result), 32'(last_r));
            check("hold error", 32'(error), 32'(last_e));
            check("hold out_valid", 32'(out_valid), 32'd0);
        end

        for (int i = 0; i < 400; i++) begin
            logic [15:0] ra, rb, rop;
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rop = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            if (i % 8 == 0) rb[3:0] = 4'd0;
            m = model(ra, rb, rop);
            run_vec($sformatf("rand%0d op%0h", i, rop), ra, rb, rop, m[16:0], m[17]);
        end

        // Asynchronous reset while out_valid is high, before the next edge.
        run_vec("pre-reset", 16'hFFFF, 16'h0001, 16'd0, 17'h10000, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst result", 32'(result), 32'd0);
        check("async rst error", 32'(error), 32'd0);
        check("async rst out_valid", 32'(out_valid), 32'd0);
        A = 16'h0001; B = 16'h0001; OP = 16'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        check("in-reset discard result", 32'(result), 32'd0);
        check("in-reset discard out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("post-reset", 16'h0002, 16'h0003, 16'd0, 17'h00005, 1'b0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("post-reset hold", 32'(result), 32'h5);
        check("post-reset out_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
